// File: rtl/pwm_demod.sv
// Duty-cycle recovery for the 8-bit bit-reversed PWM link: counts high samples over 256-cycle windows.
// Optional macro PWM_DEMOD_SYNC_EN adds a two-flop input synchronizer for asynchronous inputs.
module pwm_demod #(
  parameter int LOCK_COUNT = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       clr_in,
  input  logic       sig_in,
  output logic [7:0] dc_out,
  output logic       valid_out,
  output logic       locked_out,
  output logic       changed_out,
  output logic       sat_out
);

  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} lockState_e;

  localparam logic [3:0] LockTarget = 4'(LOCK_COUNT);

  logic       sample;
  logic [7:0] win_cnt_q;
  logic [8:0] hi_cnt_q;
  logic [8:0] total;
  logic [7:0] result;
  logic       win_end;
  logic       result_evt;
  logic       same_result;

  logic [7:0] dc_q;
  logic       sat_q;
  logic       valid_q;

  lockState_e state_q, state_d;
  logic [3:0] match_q, match_d;
  logic [7:0] prev_q, prev_d;
  logic       changed_q, changed_d;

`ifdef PWM_DEMOD_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = sig_in;
`endif

  // total reaches 256 only when every sample of the window was high
  assign win_end     = (win_cnt_q == 8'hFF);
  assign total       = hi_cnt_q + {8'd0, sample};
  assign result      = total[8] ? 8'hFF : total[7:0];
  assign result_evt  = win_end & ~clr_in;
  assign same_result = (result == prev_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      win_cnt_q <= '0;
      hi_cnt_q  <= '0;
    end else if (clr_in) begin
      win_cnt_q <= '0;
      hi_cnt_q  <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + 8'd1;
      hi_cnt_q  <= win_end ? 9'd0 : total;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dc_q    <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= result_evt;
      if (result_evt) begin
        dc_q  <= result;
        sat_q <= total[8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ACQUIRE;
      match_q   <= '0;
      prev_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_in) begin
      state_d = ACQUIRE;
    end else if (win_end) begin
      case (state_q)
        ACQUIRE: state_d = TRACK;
        TRACK:   if (same_result && ((match_q + 4'd1) == LockTarget)) state_d = LOCKED;
        LOCKED:  if (!same_result) state_d = TRACK;
        default: state_d = ACQUIRE;
      endcase
    end
  end

  always_comb begin
    match_d   = match_q;
    prev_d    = prev_q;
    changed_d = 1'b0;
    if (clr_in) begin
      match_d = '0;
    end else if (win_end) begin
      prev_d = result;
      case (state_q)
        ACQUIRE: match_d = 4'd1;
        TRACK:   match_d = same_result ? (match_q + 4'd1) : 4'd1;
        LOCKED: begin
          if (!same_result) begin
            changed_d = 1'b1;
            match_d   = 4'd1;
          end
        end
        default: match_d = '0;
      endcase
    end
  end

  assign dc_out      = dc_q;
  assign sat_out     = sat_q;
  assign valid_out   = valid_q;
  assign changed_out = changed_q;
  assign locked_out  = (state_q == LOCKED);

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Duty-cycle recovery block: the receive end of our 8-bit bit-reversed-counter PWM link. It counts high samples of a PWM line over consecutive 256-cycle windows and reports the recovered 8-bit duty code, which equals the transmitter's duty input exactly for a steady, same-clock input. It sits between a PWM-driven pin (or loopback from the PWM generator) and consumer logic such as the display or control path. It also reports lock, step-change and saturation status.

## Interface
- LOCK_COUNT, default 2: number of consecutive identical window results needed to assert lock; legal range 2..15.
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- clr_in  input  1  synchronous clear: restart the window and the lock FSM.
- sig_in  input  1  PWM line being measured.
- dc_out  output  8  last recovered duty code; reset 0.
- valid_out  output  1  one-cycle pulse when dc_out updates; reset 0.
- locked_out  output  1  result stable for LOCK_COUNT windows; reset 0.
- changed_out  output  1  one-cycle pulse when a locked result changes; reset 0.
- sat_out  output  1  last window was high for all 256 samples; reset 0.

## Operation
- Sample s: the sig_in value used for counting (see Configuration).
- win_cnt: 8 bits, starts at 0 after reset or clr_in, increments every cycle, wraps 255→0. One window is 256 cycles.
- hi_cnt: 9 bits, adds s each cycle.
- End of window (win_cnt==255): total = hi_cnt + s, 0..256. Next edge: dc_out <= min(total, 255); sat_out <= (total==256); valid_out=1 for one cycle; hi_cnt <= 0.
- Lock FSM, evaluated on each window result r compared with the previous result p:
  - ACQUIRE: no previous result. On the result, store p=r, go to TRACK, match=1.
  - TRACK: if r==p, match++; otherwise match=1. When match reaches LOCK_COUNT, go to LOCKED and assert locked_out. Always set p=r.
  - LOCKED: if r==p, stay. If r!=p, pulse changed_out, deassert locked_out, set match=1, go to TRACK. Always set p=r.
- locked_out and changed_out update on the same edge as the valid_out pulse.
- clr_in=1: win_cnt and hi_cnt go to 0; FSM goes to ACQUIRE; locked_out, changed_out and valid_out go to 0. dc_out and sat_out hold. clr_in takes priority over a coincident window end, so no valid_out is produced for that window.
- Reset asserted mid-window: all state and outputs return to their reset values immediately. The partial window is discarded.

## Timing
- Without the synchronizer, the first valid_out is asserted 256 rising edges after rst_n_in deasserts, and every 256 cycles after that.
- Without the synchronizer, sample-to-count latency is 0: the sig_in value at edge k is counted in the window containing edge k.
- With the synchronizer, sample-to-count latency is 2 cycles. Window boundaries do not move.
- dc_out, sat_out and the status outputs are registered and change only on the valid_out edge.
- Lock is asserted no earlier than the LOCK_COUNT-th valid_out after reset or clr_in.
- Arithmetic: hi_cnt must not overflow. The maximum value is 256, which fits in 9 bits. Saturation to 255 is applied only on the dc_out path.

## Configuration
- PWM_DEMOD_SYNC_EN defined: sig_in passes through a two-flop synchronizer, with both flops reset to 0, and s is the second flop's output. Use this when the input is asynchronous, e.g. a pin.
- PWM_DEMOD_SYNC_EN undefined: s = sig_in directly. Use this only for a same-clock loopback. Recovery is exact for any window phase because the transmitter's pattern is 256-periodic.

## Test plan
- Same-clock PWM generator with dc=0x5A, macro undefined -> valid_out at cycle 256 with dc_out=0x5A. locked_out rises at the second valid_out, with LOCK_COUNT=2.
- sig_in held at 1 -> dc_out=0xFF and sat_out=1 at every valid_out. sig_in held at 0 -> dc_out=0x00 and sat_out=0.
- Locked at 0x40, then the generator switches to 0xC0 mid-window -> the blended window gives an intermediate value with changed_out pulsed and locked_out=0. The following windows give 0xC0, and lock is regained after LOCK_COUNT consecutive 0xC0 results.
- clr_in asserted on the cycle where win_cnt==255 -> no valid_out, dc_out holds, and the next valid_out comes 256 cycles after clr_in.
- rst_n_in pulsed low at win_cnt=100 while locked -> all outputs 0 immediately. The first new valid_out comes 256 edges after release.
- Macro defined, dc=0x80 -> dc_out=0x80. The sample stream is delayed by 2 cycles, and window timing is unchanged.
